// File: rtl/lstm_seq_driver.sv
// Sequence controller that steps lstm_cell over SEQ_LEN timesteps and holds the recurrent h/c state.
// Optional build macro LSTM_SEQ_EMIT_ALL_EN: emit h after every timestep instead of only the last.
module lstm_seq_driver #(
  parameter int INPUT_SIZE  = 6,
  parameter int HIDDEN_SIZE = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int SEQ_LEN     = 8
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              seq_clear,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [INPUT_SIZE*DATA_WIDTH-1:0]  x_in,
  output logic                              cell_start,
  input  logic                              cell_done,
  output logic [INPUT_SIZE*DATA_WIDTH-1:0]  cell_x,
  output logic [HIDDEN_SIZE*DATA_WIDTH-1:0] cell_h_prev,
  output logic [HIDDEN_SIZE*DATA_WIDTH-1:0] cell_c_prev,
  input  logic [HIDDEN_SIZE*DATA_WIDTH-1:0] cell_h,
  input  logic [HIDDEN_SIZE*DATA_WIDTH-1:0] cell_c,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [HIDDEN_SIZE*DATA_WIDTH-1:0] out_h,
  output logic                              out_last
);

  localparam int XW = INPUT_SIZE * DATA_WIDTH;
  localparam int HW = HIDDEN_SIZE * DATA_WIDTH;
  localparam int CW = $clog2(SEQ_LEN + 1);
  localparam logic [CW-1:0] T_LAST = CW'(SEQ_LEN - 1);

  typedef enum logic [1:0] {ACCEPT, START, WAIT, EMIT} state_t;

  state_t        state, state_next;
  logic [XW-1:0] x_reg;
  logic [HW-1:0] h_reg, c_reg;
  logic [CW-1:0] t_cnt;
  logic          t_is_last;
  logic          do_clear, do_accept, do_capture, do_release;

  assign t_is_last = (t_cnt == T_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ACCEPT;
    else        state <= state_next;
  end

  // seq_clear only matters in ACCEPT and wins over in_valid there
  always_comb begin
    state_next = state;
    do_clear   = 1'b0;
    do_accept  = 1'b0;
    do_capture = 1'b0;
    do_release = 1'b0;
    case (state)
      ACCEPT: begin
        if (seq_clear) begin
          do_clear = 1'b1;
        end else if (in_valid) begin
          do_accept  = 1'b1;
          state_next = START;
        end
      end
      START: state_next = WAIT;
      WAIT: begin
        if (cell_done) begin
          do_capture = 1'b1;
`ifdef LSTM_SEQ_EMIT_ALL_EN
          state_next = EMIT;
`else
          state_next = t_is_last ? EMIT : ACCEPT;
`endif
        end
      end
      EMIT: begin
        if (out_ready) begin
          do_release = 1'b1;
          state_next = ACCEPT;
        end
      end
      default: state_next = ACCEPT;
    endcase
  end

  // t_cnt stays on the current timestep while in EMIT so out_last can be decoded from it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_reg <= '0;
      h_reg <= '0;
      c_reg <= '0;
      t_cnt <= '0;
    end else begin
      if (do_accept) x_reg <= x_in;
      if (do_clear) begin
        h_reg <= '0;
        c_reg <= '0;
        t_cnt <= '0;
      end
      if (do_capture) begin
        h_reg <= cell_h;
        c_reg <= cell_c;
`ifndef LSTM_SEQ_EMIT_ALL_EN
        if (!t_is_last) t_cnt <= t_cnt + CW'(1);
`endif
      end
      if (do_release) begin
`ifdef LSTM_SEQ_EMIT_ALL_EN
        if (t_is_last) begin
          h_reg <= '0;
          c_reg <= '0;
          t_cnt <= '0;
        end else begin
          t_cnt <= t_cnt + CW'(1);
        end
`else
        h_reg <= '0;
        c_reg <= '0;
        t_cnt <= '0;
`endif
      end
    end
  end

  assign in_ready    = (state == ACCEPT);
  assign cell_start  = (state == START);
  assign out_valid   = (state == EMIT);
  assign out_last    = (state == EMIT) && t_is_last;
  assign cell_x      = x_reg;
  assign cell_h_prev = h_reg;
  assign cell_c_prev = c_reg;
  assign out_h       = h_reg;

endmodule

// File: tb/tb_lstm_seq_driver.sv
// Scoreboard bench for lstm_seq_driver with a behavioural cell stub
// (h[j]=h_prev[j]+x[0], c[j]=c_prev[j]+1; done 2 cycles after start, or tied high).
module tb_lstm_seq_driver;
  localparam int IS = 2;
  localparam int HS = 4;
  localparam int DW = 16;
  localparam int SL = 3;
  localparam int XW = IS * DW;
  localparam int HW = HS * DW;

  logic          clk = 1'b0;
  logic          rst_n, seq_clear, in_valid, out_ready, cell_done;
  logic          in_ready, cell_start, out_valid, out_last;
  logic [XW-1:0] x_in, cell_x;
  logic [HW-1:0] cell_h_prev, cell_c_prev, cell_h, cell_c, out_h;

  lstm_seq_driver #(.INPUT_SIZE(IS), .HIDDEN_SIZE(HS), .DATA_WIDTH(DW), .SEQ_LEN(SL)) dut (
    .clk(clk), .rst_n(rst_n), .seq_clear(seq_clear), .in_valid(in_valid), .in_ready(in_ready),
    .x_in(x_in), .cell_start(cell_start), .cell_done(cell_done), .cell_x(cell_x),
    .cell_h_prev(cell_h_prev), .cell_c_prev(cell_c_prev), .cell_h(cell_h), .cell_c(cell_c),
    .out_valid(out_valid), .out_ready(out_ready), .out_h(out_h), .out_last(out_last)
  );

  always #5 clk = ~clk;

  // cell stub: results are combinational from the driver's registers, done is timed separately
  logic       comb_mode;
  logic [1:0] dcnt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)            dcnt <= 2'd0;
    else if (cell_start)   dcnt <= 2'd2;
    else if (dcnt != 2'd0) dcnt <= dcnt - 2'd1;
  end
  always_comb begin
    cell_h    = '0;
    cell_c    = '0;
    cell_done = comb_mode ? 1'b1 : (dcnt == 2'd1);
    for (int j = 0; j < HS; j++) begin
      cell_h[j*DW +: DW] = cell_h_prev[j*DW +: DW] + cell_x[DW-1:0];
      cell_c[j*DW +: DW] = cell_c_prev[j*DW +: DW] + DW'(1);
    end
  end

  int            total = 0;
  int            bad = 0;
  int            start_count = 0;
  logic          prev_start = 1'b0;
  int            model_h, model_t;
  logic [HW:0]   exp_q[$];
  logic [HW:0]   mon_e;

  task automatic checkOutput(input string tag, input logic [HW-1:0] obs, input logic [HW-1:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [HW-1:0] rep(input int v);
    logic [HW-1:0] r;
    for (int j = 0; j < HS; j++) r[j*DW +: DW] = DW'(v);
    return r;
  endfunction

  // output monitor: a handshake seen at the falling edge completes on the next rising edge
  always @(negedge clk) begin
    if (rst_n && cell_start) begin
      start_count++;
      checkOutput("start_width", HW'(prev_start), '0);
    end
    prev_start = rst_n && cell_start;
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_out", '1, '0);
      end else begin
        mon_e = exp_q.pop_front();
        checkOutput("out_h", out_h, mon_e[HW-1:0]);
        checkOutput("out_last", HW'(out_last), HW'(mon_e[HW]));
      end
    end
  end

  task automatic applyStimulus(input int x0);
    logic [XW-1:0] xv;
    int n;
    @(negedge clk);
    xv = '0;
    xv[DW-1:0] = DW'(x0);
    xv[XW-1:DW] = (XW-DW)'($urandom);
    x_in = xv;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checkOutput("accept_timeout", '0, '1);
      in_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1 in_valid = 1'b0;
      checkOutput("cell_x", HW'(cell_x), HW'(xv));
      model_h += x0;
      model_t++;
`ifdef LSTM_SEQ_EMIT_ALL_EN
      exp_q.push_back({model_t == SL, rep(model_h)});
      if (model_t == SL) begin
        model_h = 0;
        model_t = 0;
      end
`else
      if (model_t == SL) begin
        exp_q.push_back({1'b1, rep(model_h)});
        model_h = 0;
        model_t = 0;
      end
`endif
    end
  endtask

  task automatic waitDrain(input string tag);
    int n = 0;
    while ((exp_q.size() != 0 || !in_ready) && n < 300) begin
      @(negedge clk);
      n++;
    end
    checkOutput(tag, HW'(exp_q.size()), '0);
    @(negedge clk);
  endtask

  task automatic waitReady(input string tag);
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    checkOutput(tag, HW'(in_ready), HW'(1));
  endtask

  initial begin
    #300000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int sc;
    int n;
    rst_n = 1'b0; seq_clear = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    x_in = '0; comb_mode = 1'b0; model_h = 0; model_t = 0;
    repeat (2) @(negedge clk);
    checkOutput("rst_in_ready", HW'(in_ready), HW'(1));
    checkOutput("rst_cell_start", HW'(cell_start), '0);
    checkOutput("rst_out_valid", HW'(out_valid), '0);
    checkOutput("rst_out_last", HW'(out_last), '0);
    checkOutput("rst_cell_x", HW'(cell_x), '0);
    checkOutput("rst_h", cell_h_prev, '0);
    checkOutput("rst_c", cell_c_prev, '0);
    checkOutput("rst_out_h", out_h, '0);
    rst_n = 1'b1;

    // basic sequence with delayed done
    applyStimulus(1);
    applyStimulus(2);
    applyStimulus(3);
    waitDrain("t1_drain");
    checkOutput("t1_h_cleared", cell_h_prev, '0);
    checkOutput("t1_c_cleared", cell_c_prev, '0);

    // combinational cell: capture lands one cycle after each start pulse
    comb_mode = 1'b1;
    sc = start_count;
    for (int i = 0; i < SL; i++) begin
      applyStimulus(5);
      @(negedge clk);
      checkOutput("t2_start", HW'(cell_start), HW'(1));
      @(negedge clk);
      checkOutput("t2_wait_ready", HW'(in_ready), '0);
      checkOutput("t2_wait_start", HW'(cell_start), '0);
      @(negedge clk);
`ifdef LSTM_SEQ_EMIT_ALL_EN
      checkOutput("t2_emit", HW'(out_valid), HW'(1));
`else
      if (i < SL - 1) begin
        checkOutput("t2_capture", HW'(in_ready), HW'(1));
        checkOutput("t2_h", cell_h_prev, rep(5 * (i + 1)));
      end else begin
        checkOutput("t2_emit", HW'(out_valid), HW'(1));
      end
`endif
    end
    waitDrain("t2_drain");
    checkOutput("t2_starts", HW'(start_count - sc), HW'(SL));
    comb_mode = 1'b0;

    // downstream backpressure in EMIT
    out_ready = 1'b0;
    applyStimulus(1);
    applyStimulus(1);
    applyStimulus(1);
    n = 0;
    while (!out_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    sc = start_count;
    repeat (10) begin
      @(negedge clk);
      checkOutput("t3_valid", HW'(out_valid), HW'(1));
      checkOutput("t3_out_h", out_h, rep(3));
      checkOutput("t3_in_ready", HW'(in_ready), '0);
    end
    checkOutput("t3_c", cell_c_prev, rep(3));
    checkOutput("t3_no_start", HW'(start_count - sc), '0);
    out_ready = 1'b1;
    waitDrain("t3_drain");

    // seq_clear beats in_valid in ACCEPT
    applyStimulus(4);
    waitReady("t4_ready");
    checkOutput("t4_h_before", cell_h_prev, rep(4));
    x_in = XW'(9);
    seq_clear = 1'b1;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    seq_clear = 1'b0;
    in_valid = 1'b0;
    model_h = 0;
    model_t = 0;
    checkOutput("t4_in_ready", HW'(in_ready), HW'(1));
    checkOutput("t4_no_start", HW'(cell_start), '0);
    checkOutput("t4_h", cell_h_prev, '0);
    checkOutput("t4_c", cell_c_prev, '0);
    applyStimulus(1);
    applyStimulus(1);
    applyStimulus(1);
    waitDrain("t4_drain");

    // reset during WAIT of the second timestep
    applyStimulus(1);
    applyStimulus(2);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    model_h = 0;
    model_t = 0;
    checkOutput("t5_in_ready", HW'(in_ready), HW'(1));
    checkOutput("t5_start", HW'(cell_start), '0);
    checkOutput("t5_out_valid", HW'(out_valid), '0);
    checkOutput("t5_out_last", HW'(out_last), '0);
    checkOutput("t5_h", cell_h_prev, '0);
    checkOutput("t5_c", cell_c_prev, '0);
    checkOutput("t5_x", HW'(cell_x), '0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) begin
      @(negedge clk);
      checkOutput("t5_idle_valid", HW'(out_valid), '0);
    end
    applyStimulus(1);
    applyStimulus(2);
    applyStimulus(3);
    waitDrain("t5_drain");

    checkOutput("queue_empty", HW'(exp_q.size()), '0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
